// File: rtl/tug_of_war_lights_if.sv
// Player-side bundle for the tug-of-war playfield: the two conditioned
// button levels going in and the one-hot LED bar coming back out.
// The master side belongs to whatever drives the buttons and watches the
// bar; the slave side belongs to the playfield controller itself.
interface tug_of_war_lights_if;
    logic       L;
    logic       R;
    logic [9:1] led;

    modport master (
        output L,
        output R,
        input  led
    );

    modport slave (
        input  L,
        input  R,
        output led
    );
endinterface

// File: rtl/tug_of_war_lights.sv
// Playfield controller for a two-player tug-of-war on a 9-LED bar.
// The rope position is held directly as a one-hot vector, so the LED bar
// is simply that register; bit 9 is the left end and bit 1 the right end.
// A small two-state machine tracks whether the game is still being played
// or has been won, in which case the bar stays frozen until reset.
module tug_of_war_lights (
    input  logic                 clk,
    input  logic                 reset,
    tug_of_war_lights_if.slave   bus
);

    typedef enum logic {
        PLAYING,
        GAME_OVER
    } state_t;

    localparam logic [9:1] CENTRE = 9'b000010000;

    state_t     state_q, state_d;
    logic [9:1] pos_q, pos_d;

    // Register the rope position and the game state; reset snaps the light
    // straight back to the centre and reopens play, independent of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q   <= CENTRE;
            state_q <= PLAYING;
        end else begin
            pos_q   <= pos_d;
            state_q <= state_d;
        end
    end

    // While playing, an uncontested button pulls the light one LED toward its
    // owner each cycle; landing on either end LED ends the game on that edge.
    always_comb begin
        pos_d   = pos_q;
        state_d = state_q;
        case (state_q)
            PLAYING: begin
                if (bus.L && !bus.R) begin
                    pos_d = {pos_q[8:1], 1'b0};
                end else if (bus.R && !bus.L) begin
                    pos_d = {1'b0, pos_q[9:2]};
                end
                if (pos_d[9] || pos_d[1]) begin
                    state_d = GAME_OVER;
                end
            end
            GAME_OVER: begin
                pos_d   = pos_q;
                state_d = GAME_OVER;
            end
            default: begin
                pos_d   = CENTRE;
                state_d = PLAYING;
            end
        endcase
    end

    assign bus.led = pos_q;

endmodule

// File: tb/tb_tug_of_war_lights.sv
// Self-checking bench for the tug-of-war playfield.
// A reference model keeps the rope position as a plain integer 1..9 and a
// won flag, derived from the game rules, and the expected bar is the bit at
// that position. Directed scenarios walk the listed game situations, then a
// randomized section plays many games with occasional asynchronous resets.
module tb_tug_of_war_lights;

    logic clk;
    logic reset;

    tug_of_war_lights_if bus ();

    tug_of_war_lights dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int modelPos;
    bit modelWon;

    // Free-running clock, 10 time units per period, rising edges at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the required one and log a mismatch.
    task automatic checkOutput(input string tag, input logic [9:1] observed,
                               input logic [9:1] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, required %b", tag, observed, expected);
        end
    endtask

    // Expected bar for the model's current position.
    function automatic logic [9:1] modelLed();
        logic [9:1] v;
        v = '0;
        v[modelPos] = 1'b1;
        return v;
    endfunction

    // Check the bar against the model and also check it is strictly one-hot.
    task automatic checkBar(input string tag);
        checkOutput(tag, bus.led, modelLed());
        checkOutput({tag, "_onehot"}, {8'b0, $onehot(bus.led)}, 9'd1);
    endtask

    // Drive one cycle of buttons, clock it, then advance the model by the rules.
    task automatic applyStimulus(input logic l, input logic r, input string tag);
        bus.L = l;
        bus.R = r;
        @(posedge clk);
        #1;
        if (!modelWon) begin
            if (l && !r)      modelPos = modelPos + 1;
            else if (r && !l) modelPos = modelPos - 1;
            if (modelPos == 9 || modelPos == 1) modelWon = 1'b1;
        end
        checkBar(tag);
    endtask

    // Hold reset across one rising edge, with random button levels that must be ignored.
    task automatic resetWithClock();
        reset = 1'b1;
        bus.L = 1'($urandom);
        bus.R = 1'($urandom);
        @(posedge clk);
        #1;
        modelPos = 5;
        modelWon = 1'b0;
        checkBar("reset_clocked");
        reset = 1'b0;
        bus.L = 1'b0;
        bus.R = 1'b0;
    endtask

    // Pulse reset between clock edges and confirm the bar recentres before any edge.
    task automatic asyncReset(input string tag);
        #1;
        reset = 1'b1;
        #2;
        modelPos = 5;
        modelWon = 1'b0;
        checkBar(tag);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        bus.L    = 1'b0;
        bus.R    = 1'b0;
        modelPos = 5;
        modelWon = 1'b0;
        #2;
        checkOutput("reset_immediate", bus.led, 9'b000010000);
        @(negedge clk);

        // Idle after reset.
        resetWithClock();
        checkOutput("reset_centre", bus.led, 9'b000010000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "idle");

        // Left player wins in four cycles, then stays frozen.
        resetWithClock();
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, "left_run");
        checkOutput("left_win", bus.led, 9'b100000000);

        // Right player wins, then every input combination is ignored.
        resetWithClock();
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, "right_run");
        checkOutput("right_win", bus.led, 9'b000000001);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, "over_tie");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, "over_left");
        checkOutput("right_frozen", bus.led, 9'b000000001);

        // Mid-game ties and a change of direction without a win.
        resetWithClock();
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, "mid_left");
        checkOutput("mid_at7", bus.led, 9'b001000000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, "mid_tie");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, "mid_right");
        checkOutput("mid_at3", bus.led, 9'b000000100);

        // Asynchronous reset while at led[8].
        resetWithClock();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "to8");
        checkOutput("at8", bus.led, 9'b010000000);
        asyncReset("async_from8");

        // Asynchronous reset after a left win, then play resumes normally.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, "to9");
        asyncReset("async_from9");
        applyStimulus(1'b0, 1'b1, "after_reset_right");
        checkOutput("after_reset_at4", bus.led, 9'b000001000);

        // Randomized games: left-biased, right-biased or fair button mixes,
        // with an occasional asynchronous reset dropped into the middle.
        for (int g = 0; g < 40; g++) begin
            int bias;
            bias = int'($urandom_range(0, 2));
            resetWithClock();
            for (int c = 0; c < 25; c++) begin
                logic l, r;
                int roll;
                roll = int'($urandom_range(0, 99));
                case (bias)
                    0:       begin l = (roll < 70); r = (roll >= 55); end
                    1:       begin l = (roll < 30); r = (roll >= 15); end
                    default: begin l = 1'($urandom); r = 1'($urandom); end
                endcase
                applyStimulus(l, r, "random");
                if ($urandom_range(0, 49) == 0) asyncReset("random_async");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tug_of_war_lights.md
Name: tug_of_war_lights

Overview:
Playfield controller for a two-player tug-of-war game on a 9-LED bar, led[9] at the left end and led[1] at the right end.
- Exactly one LED is lit; it marks the current rope position.
- Each clock cycle in which exactly one player's button is asserted, the light moves one step toward that player.
- When the light reaches an end LED, that player has won and the bar freezes until reset.
- Sits between the conditioned player button inputs and the board LEDs.

Parameters:
- None. The bar width is fixed at 9 LEDs and the start position is fixed at the centre, led[5].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces the start state immediately.
- L  input  1  left player button, active-high, level-sensitive, sampled every rising clk edge.
- R  input  1  right player button, active-high, level-sensitive, sampled every rising clk edge.
- led  output  [9:1]  one-hot light position; led[9] is the left end, led[5] the centre, led[1] the right end.

Behaviour:
- State: position register P, range 1..9, plus a 1-bit game-over flag G. The one-hot encoding of P may serve directly as the register.
- Output: led[P] = 1, all other bits 0. led is driven directly from registers (no combinational path from L/R), so it changes only on a clk edge or on reset.
- Reset (asynchronous, active-high): P = 5, G = 0, so led = 9'b000010000, while reset is high and immediately on assertion. Inputs are ignored while reset is high.
- Reset mid-game, or after game over, restores the centre position; the next clk edge after reset deasserts is a normal playing cycle.
- Playing (G = 0), on each rising clk edge:
  - L=1, R=0: P = P+1, one step left.
  - L=0, R=1: P = P-1, one step right.
  - L=R=0 or L=R=1: P unchanged (tie, no movement).
- Movement is per cycle while a button is held; there is no edge detection. A held button advances one LED per clock.
- Win detection: if the update makes P = 9 (left win) or P = 1 (right win), G is set on the same edge.
- Game over (G = 1):
  - P and led are frozen; all L/R combinations are ignored.
  - Only reset leaves this state.
- P never leaves 1..9. From the centre, a win takes exactly 4 consecutive uncontested cycles.
- No metastability handling in this block; L and R are synchronous to clk, and synchronisation/debounce is done upstream.
- Invariant: $onehot(led) holds at all times after reset.

Test Plan:
- Assert reset, L=R=0, one clock, deassert -> led = 000010000; hold L=R=0 for 3 cycles -> unchanged.
- reset, then hold L=1, R=0 for 14 cycles -> led[6], led[7], led[8], led[9] after cycles 1-4; led = 100000000 for all remaining cycles (frozen).
- reset, then hold R=1, L=0 for 14 cycles -> led[4], led[3], led[2], led[1] after cycles 1-4; then frozen at 000000001.
  - Continue with L=R=1 for 4 cycles, then R=0, L=1 for 5 cycles -> led stays 000000001 (game over ignores inputs).
- Mid-game tie/alternation: from the centre, L for 2 cycles (led[7]), then L=R=1 for 3 cycles (led[7]), then R for 4 cycles -> led[6], led[5], led[4], led[3]; no win.
- Asynchronous reset: assert reset between clk edges while at led[8] -> led = 000010000 before the next edge.
  - Also assert reset while frozen at led[9] -> centre; a subsequent R press moves to led[4].
